// File: rtl/exe_wb_pipe.sv
// EXE -> WB pipeline register with valid/ready handshake, forwarding lookup
// over held entries and a saturating back-pressure counter.
// Optional macro EXE_WB_SKID_EN adds a skid entry behind the main entry so
// that in_ready becomes a registered signal. When the macro is undefined the
// block holds a single entry and in_ready is combinational.
module exe_wb_pipe #(
  parameter int ASIZE = 5,
  parameter int DSIZE = 32,
  parameter int CNTW  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_wen,
  input  logic [ASIZE-1:0] in_waddr,
  input  logic [DSIZE-1:0] in_aluout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_wen,
  output logic [ASIZE-1:0] out_waddr,
  output logic [DSIZE-1:0] out_aluout,
  input  logic [ASIZE-1:0] fwd_raddr,
  output logic             fwd_hit,
  output logic [DSIZE-1:0] fwd_data,
  output logic [CNTW-1:0]  stall_cnt
);

  // Saturating increment for the stall counter.
  function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] c);
    logic [CNTW-1:0] one;
    one = {{(CNTW-1){1'b0}}, 1'b1};
    return (&c) ? c : c + one;
  endfunction

  // Register 0 is hard-wired, so a write to it is squashed on entry.
  function automatic logic eff_wen(input logic wen, input logic [ASIZE-1:0] addr);
    return wen && (addr != '0);
  endfunction

  // Main entry (always drives the WB side)
  logic             vld_p1;
  logic             wen_p1;
  logic [ASIZE-1:0] waddr_p1;
  logic [DSIZE-1:0] data_p1;

  logic             vld_nxt;
  logic             wen_nxt;
  logic [ASIZE-1:0] waddr_nxt;
  logic [DSIZE-1:0] data_nxt;

  logic [CNTW-1:0]  stall_p1;
  logic [CNTW-1:0]  stall_nxt;

  logic             in_xfer;
  logic             out_xfer;
  logic             in_wen_eff;

  assign in_xfer    = in_valid && in_ready;
  assign out_xfer   = vld_p1 && out_ready;
  assign in_wen_eff = eff_wen(in_wen, in_waddr);

`ifdef EXE_WB_SKID_EN
  // Skid entry: catches a word accepted while main is held and not leaving.
  logic             skid_vld_p1;
  logic             skid_wen_p1;
  logic [ASIZE-1:0] skid_waddr_p1;
  logic [DSIZE-1:0] skid_data_p1;

  logic             skid_vld_nxt;
  logic             skid_wen_nxt;
  logic [ASIZE-1:0] skid_waddr_nxt;
  logic [DSIZE-1:0] skid_data_nxt;

  logic             in_ready_p1;

  assign in_ready = in_ready_p1;

  // Next-state for main and skid: skid refills main whenever main frees up.
  always_comb begin
    vld_nxt        = vld_p1;
    wen_nxt        = wen_p1;
    waddr_nxt      = waddr_p1;
    data_nxt       = data_p1;
    skid_vld_nxt   = skid_vld_p1;
    skid_wen_nxt   = skid_wen_p1;
    skid_waddr_nxt = skid_waddr_p1;
    skid_data_nxt  = skid_data_p1;
    if (flush) begin
      vld_nxt      = 1'b0;
      skid_vld_nxt = 1'b0;
    end else if (!vld_p1 || out_xfer) begin
      if (skid_vld_p1) begin
        vld_nxt      = 1'b1;
        wen_nxt      = skid_wen_p1;
        waddr_nxt    = skid_waddr_p1;
        data_nxt     = skid_data_p1;
        skid_vld_nxt = in_xfer;
        if (in_xfer) begin
          skid_wen_nxt   = in_wen_eff;
          skid_waddr_nxt = in_waddr;
          skid_data_nxt  = in_aluout;
        end
      end else begin
        vld_nxt = in_xfer;
        if (in_xfer) begin
          wen_nxt   = in_wen_eff;
          waddr_nxt = in_waddr;
          data_nxt  = in_aluout;
        end
      end
    end else if (in_xfer) begin
      skid_vld_nxt   = 1'b1;
      skid_wen_nxt   = in_wen_eff;
      skid_waddr_nxt = in_waddr;
      skid_data_nxt  = in_aluout;
    end
  end

  // Skid entry and registered ready (ready == skid will be empty).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      skid_vld_p1   <= 1'b0;
      skid_wen_p1   <= 1'b0;
      skid_waddr_p1 <= '0;
      skid_data_p1  <= '0;
      in_ready_p1   <= 1'b1;
    end else begin
      skid_vld_p1   <= skid_vld_nxt;
      skid_wen_p1   <= skid_wen_nxt;
      skid_waddr_p1 <= skid_waddr_nxt;
      skid_data_p1  <= skid_data_nxt;
      in_ready_p1   <= !skid_vld_nxt;
    end
  end
`else
  assign in_ready = !vld_p1 || out_ready;

  // Next-state for the single entry: load on accept, empty on leave.
  always_comb begin
    vld_nxt   = vld_p1;
    wen_nxt   = wen_p1;
    waddr_nxt = waddr_p1;
    data_nxt  = data_p1;
    if (flush) begin
      vld_nxt = 1'b0;
    end else if (in_xfer) begin
      vld_nxt   = 1'b1;
      wen_nxt   = in_wen_eff;
      waddr_nxt = in_waddr;
      data_nxt  = in_aluout;
    end else if (out_xfer) begin
      vld_nxt = 1'b0;
    end
  end
`endif

  // Stall counter: counts held-but-not-taken cycles, clears otherwise.
  always_comb begin
    stall_nxt = '0;
    if (!flush && vld_p1 && !out_ready) begin
      stall_nxt = sat_inc(stall_p1);
    end
  end

  // Main entry and stall counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1   <= 1'b0;
      wen_p1   <= 1'b0;
      waddr_p1 <= '0;
      data_p1  <= '0;
      stall_p1 <= '0;
    end else begin
      vld_p1   <= vld_nxt;
      wen_p1   <= wen_nxt;
      waddr_p1 <= waddr_nxt;
      data_p1  <= data_nxt;
      stall_p1 <= stall_nxt;
    end
  end

  // Forwarding lookup: youngest matching valid entry wins.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    if (fwd_raddr != '0) begin
`ifdef EXE_WB_SKID_EN
      if (skid_vld_p1 && skid_wen_p1 && (skid_waddr_p1 == fwd_raddr)) begin
        fwd_hit  = 1'b1;
        fwd_data = skid_data_p1;
      end else if (vld_p1 && wen_p1 && (waddr_p1 == fwd_raddr)) begin
        fwd_hit  = 1'b1;
        fwd_data = data_p1;
      end
`else
      if (vld_p1 && wen_p1 && (waddr_p1 == fwd_raddr)) begin
        fwd_hit  = 1'b1;
        fwd_data = data_p1;
      end
`endif
    end
  end

  assign out_valid  = vld_p1;
  assign out_wen    = wen_p1;
  assign out_waddr  = waddr_p1;
  assign out_aluout = data_p1;
  assign stall_cnt  = stall_p1;

endmodule
